// File: rtl/exec_controller.sv
// Execution sequencer: turns debounced step/run switches into a one-cycle CPU clock
// enable, paces free-run mode and halts on a PC breakpoint or a jump-to-self loop.
module exec_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned RUN_DIV         = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_btn,
   input  logic        run_sw,
   input  logic        bp_en,
   input  logic [7:0]  bp_addr,
   input  logic [7:0]  pc,
   output logic        cpu_ce,
   output logic        halted,
   output logic [15:0] cycle_count,
   output logic [2:0]  state
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DIV_W = $clog2(RUN_DIV + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_EXEC     = 3'b001,
      ST_CHECK    = 3'b010,
      ST_RUN_WAIT = 3'b011,
      ST_HALT     = 3'b100
   } state_e;

   // Switch path, bit 0 = step, bit 1 = run.
   logic [1:0]            sw_raw;
   logic [1:0]            meta_q;
   logic [1:0]            sync_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic                  step_dly_q;
   logic                  step_edge;
   logic                  run_deb;

   // Sequencer.
   state_e                state_q, state_d;
   logic                  mode_run_q, mode_run_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [7:0]            prev_pc_q, prev_pc_d;
   logic [15:0]           cnt_q, cnt_d;

   assign sw_raw    = {run_sw, step_btn};
   assign step_edge = deb_q[0] & ~step_dly_q;
   assign run_deb   = deb_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q     <= '0;
         sync_q     <= '0;
         deb_q      <= '0;
         db_cnt_q   <= '0;
         step_dly_q <= 1'b0;
      end else begin
         meta_q     <= sw_raw;
         sync_q     <= meta_q;
         deb_q      <= deb_d;
         db_cnt_q   <= db_cnt_d;
         step_dly_q <= deb_q[0];
      end
   end

   // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mode_run_q <= 1'b0;
         div_q      <= '0;
         prev_pc_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mode_run_q <= mode_run_d;
         div_q      <= div_d;
         prev_pc_q  <= prev_pc_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_run_d = mode_run_q;
      div_d      = div_q;
      prev_pc_d  = prev_pc_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run_deb) begin
               state_d    = ST_RUN_WAIT;
               mode_run_d = 1'b1;
               div_d      = '0;
            end else if (step_edge) begin
               state_d    = ST_EXEC;
               mode_run_d = 1'b0;
            end
         end
         ST_RUN_WAIT: begin
            div_d = div_q + DIV_W'(1);
            if (!run_deb) begin
               state_d = ST_IDLE;
            end else if (div_q == DIV_LAST) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            prev_pc_d = pc;
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // pc here already reflects the instruction just executed.
            if (pc == prev_pc_q) begin
               state_d = ST_HALT;
            end else if (bp_en && (pc == bp_addr)) begin
               state_d = ST_HALT;
            end else if (mode_run_q && run_deb) begin
               state_d = ST_RUN_WAIT;
               div_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (step_edge) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_ce = (state_q == ST_EXEC);
      halted = (state_q == ST_HALT);
      state  = state_q;
   end

   assign cycle_count = cnt_q;

   a_ce_single: assert property (@(posedge clk) disable iff (reset) cpu_ce |=> !cpu_ce);
   a_ce_not_halted: assert property (@(posedge clk) disable iff (reset) !(cpu_ce && halted));

endmodule

// File: tb/tb_exec_controller.sv
// Randomized bench for exec_controller: pulse timing derived from debounce and run-rate
// arithmetic, plus a second instance with RUN_DIV=1 for counter saturation.
module tb_exec_controller;

   localparam int D      = 4;
   localparam int RD     = 3;
   localparam int PER    = RD + 2;
   localparam int SAT_N  = 66000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset, step_btn, run_sw, bp_en;
   logic [7:0]  bp_addr, pc;
   logic        cpu_ce, halted;
   logic [15:0] cycle_count;
   logic [2:0]  state;

   logic        sat_reset, sat_step, sat_run, sat_bp_en;
   logic [7:0]  sat_bp_addr, sat_pc;
   logic        sat_ce, sat_halted;
   logic [15:0] sat_cc;
   logic [2:0]  sat_state;
   logic        sat_done = 1'b0;

   exec_controller #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD)) u_dut (
      .clk(clk), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .cpu_ce(cpu_ce), .halted(halted), .cycle_count(cycle_count), .state(state)
   );

   exec_controller #(.DEBOUNCE_CYCLES(D), .RUN_DIV(1)) u_sat (
      .clk(clk), .reset(sat_reset), .step_btn(sat_step), .run_sw(sat_run),
      .bp_en(sat_bp_en), .bp_addr(sat_bp_addr), .pc(sat_pc),
      .cpu_ce(sat_ce), .halted(sat_halted), .cycle_count(sat_cc), .state(sat_state)
   );

   // Datapath PC models.
   logic       pc_set = 1'b0;
   logic       pc_hold = 1'b0;
   logic [7:0] pc_set_val = 8'h00;
   always @(posedge clk) begin
      if (pc_set) pc <= pc_set_val;
      else if (cpu_ce && !pc_hold) pc <= pc + 8'd1;
   end
   always @(posedge clk) begin
      if (sat_reset) sat_pc <= 8'h00;
      else if (sat_ce) sat_pc <= sat_pc + 8'd1;
   end

   // Scoreboard: cycle numbers at which cpu_ce is expected / observed high.
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   always @(negedge clk) if (cpu_ce) obs_q.push_back(cyc);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic cmp_pulses(input string tag);
      check_eq({tag, "_npulse"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq($sformatf("%s_t%0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; step_btn = 1'b0; run_sw = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_pc(input logic [7:0] v);
      @(negedge clk);
      pc_set = 1'b1; pc_set_val = v;
      @(negedge clk);
      pc_set = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Saturation run on the RUN_DIV=1 instance, concurrent with the main sequence.
   initial begin : sat_proc
      int n, last, bad_gap, bad_cc, bad_pc, guard;
      logic [15:0] want_cc;
      n = 0; last = 0; bad_gap = 0; bad_cc = 0; bad_pc = 0; guard = 0;
      sat_reset = 1'b1; sat_step = 1'b0; sat_run = 1'b0; sat_bp_en = 1'b0; sat_bp_addr = 8'h00;
      repeat (2) @(negedge clk);
      sat_reset = 1'b0; sat_run = 1'b1;
      while (n < SAT_N && guard < SAT_N * 3 + 200) begin
         @(negedge clk);
         guard++;
         if (sat_ce) begin
            n++;
            if (n > 1 && (cyc - last) != 3) bad_gap++;
            last = cyc;
            want_cc = (n - 1 > 65535) ? 16'hFFFF : 16'(n - 1);
            if (sat_cc !== want_cc) bad_cc++;
            if (sat_pc !== 8'(n - 1)) bad_pc++;
         end
      end
      check_eq("sat_pulses", n, SAT_N);
      check_eq("sat_bad_gaps", bad_gap, 0);
      check_eq("sat_bad_count", bad_cc, 0);
      check_eq("sat_bad_pc", bad_pc, 0);
      settle(3);
      check_eq("sat_final_count", sat_cc, 16'hFFFF);
      check_eq("sat_not_halted", sat_halted, 1'b0);
      sat_done = 1'b1;
   end

   initial begin : main_proc
      int n0, m0, hold, x, len, t, start;
      logic [7:0] v;

      reset = 1'b1; step_btn = 1'b0; run_sw = 1'b0; bp_en = 1'b0; bp_addr = 8'h00;
      repeat (2) @(negedge clk);
      check_eq("rst_cpu_ce", cpu_ce, 1'b0);
      check_eq("rst_halted", halted, 1'b0);
      check_eq("rst_count", cycle_count, 16'h0);
      check_eq("rst_state", state, 3'b000);
      reset = 1'b0;
      settle(1);
      check_eq("rel_state", state, 3'b000);

      // Single steps with random hold times, interleaved with sub-threshold glitches.
      start = $urandom_range(0, 200);
      set_pc(8'(start));
      obs_q.delete(); exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         if (k == 1 || $urandom_range(0, 1) == 1) begin
            len = $urandom_range(1, D - 1);
            @(negedge clk);
            step_btn = 1'b1;
            settle(len);
            step_btn = 1'b0;
            settle(3 * D);
         end
         hold = (k == 0) ? 20 : $urandom_range(D, 20);
         @(negedge clk);
         n0 = cyc;
         step_btn = 1'b1;
         exp_q.push_back(n0 + D + 3);
         wait_until(n0 + hold);
         step_btn = 1'b0;
         settle(2 * D + 8);
         check_eq("step_state_idle", state, 3'b000);
      end
      cmp_pulses("step");
      check_eq("step_count", cycle_count, 16'd4);
      check_eq("step_pc", pc, 8'(start + 4));

      // Free run, stopped after a random time.
      do_reset();
      set_pc(8'h00);
      obs_q.delete(); exp_q.delete();
      len = $urandom_range(27, 60);
      @(negedge clk);
      n0 = cyc;
      run_sw = 1'b1;
      m0 = n0 + len;
      for (t = n0 + D + 3 + RD; t <= m0 + D + 2; t += PER) exp_q.push_back(t);
      wait_until(n0 + D + 3 + RD + 3 * PER + 1);
      check_eq("run_pc_after4", pc, 8'h04);
      wait_until(m0);
      run_sw = 1'b0;
      wait_until(m0 + D + 4);
      check_eq("run_stop_state", state, 3'b000);
      x = exp_q.size();
      settle(12);
      cmp_pulses("run");
      check_eq("run_pc", pc, 8'(x));
      check_eq("run_count", cycle_count, 16'(x));

      // Breakpoint halt in run mode.
      do_reset();
      set_pc(8'h00);
      obs_q.delete(); exp_q.delete();
      x = $urandom_range(3, 9);
      bp_addr = 8'(x);
      bp_en = 1'b1;
      @(negedge clk);
      n0 = cyc;
      run_sw = 1'b1;
      for (int k = 0; k < x; k++) exp_q.push_back(n0 + D + 3 + RD + k * PER);
      t = n0 + D + 3 + RD + (x - 1) * PER + 2;
      wait_until(t - 1);
      check_eq("bp_halted_early", halted, 1'b0);
      wait_until(t);
      check_eq("bp_halted", halted, 1'b1);
      check_eq("bp_state", state, 3'b100);
      settle(20);
      cmp_pulses("bp_run");
      check_eq("bp_count", cycle_count, 16'(x));
      check_eq("bp_pc", pc, 8'(x));
      run_sw = 1'b0;
      settle(2 * D + 6);
      check_eq("bp_run_off_halted", halted, 1'b1);

      // Step press leaves HALT without executing.
      hold = $urandom_range(D, 12);
      @(negedge clk);
      n0 = cyc;
      step_btn = 1'b1;
      wait_until(n0 + D + 2);
      check_eq("unhalt_still", halted, 1'b1);
      wait_until(n0 + D + 3);
      check_eq("unhalt_halted", halted, 1'b0);
      check_eq("unhalt_state", state, 3'b000);
      wait_until(n0 + hold);
      step_btn = 1'b0;
      settle(2 * D + 8);
      cmp_pulses("unhalt");
      check_eq("unhalt_count", cycle_count, 16'(x));

      // Next step from the breakpoint PC executes once and does not re-halt.
      @(negedge clk);
      n0 = cyc;
      step_btn = 1'b1;
      exp_q.push_back(n0 + D + 3);
      wait_until(n0 + hold);
      step_btn = 1'b0;
      settle(2 * D + 8);
      cmp_pulses("bp_resume");
      check_eq("bp_resume_pc", pc, 8'(x + 1));
      check_eq("bp_resume_halted", halted, 1'b0);
      check_eq("bp_resume_state", state, 3'b000);
      check_eq("bp_resume_count", cycle_count, 16'(x + 1));
      bp_en = 1'b0;

      // Jump-to-self: PC held constant.
      do_reset();
      v = 8'($urandom_range(0, 255));
      set_pc(v);
      pc_hold = 1'b1;
      obs_q.delete(); exp_q.delete();
      hold = $urandom_range(D, 15);
      @(negedge clk);
      n0 = cyc;
      step_btn = 1'b1;
      exp_q.push_back(n0 + D + 3);
      wait_until(n0 + D + 4);
      check_eq("jself_halted_early", halted, 1'b0);
      wait_until(n0 + D + 5);
      check_eq("jself_halted", halted, 1'b1);
      wait_until(n0 + hold);
      step_btn = 1'b0;
      settle(2 * D + 8);
      cmp_pulses("jself");
      check_eq("jself_count", cycle_count, 16'd1);
      check_eq("jself_pc", pc, v);
      pc_hold = 1'b0;

      // Reset while waiting in run mode.
      do_reset();
      set_pc(8'h00);
      @(negedge clk);
      run_sw = 1'b1;
      t = 0;
      while (state !== 3'b011 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("rst_rw_reached", t < 100, 1'b1);
      reset = 1'b1;
      #1;
      check_eq("rst_rw_state", state, 3'b000);
      check_eq("rst_rw_ce", cpu_ce, 1'b0);
      run_sw = 1'b0;
      settle(2);
      reset = 1'b0;
      obs_q.delete(); exp_q.delete();
      settle(30);
      cmp_pulses("rst_rw_after");
      check_eq("rst_rw_after_state", state, 3'b000);

      // Reset during the enable pulse itself.
      @(negedge clk);
      run_sw = 1'b1;
      t = 0;
      while (cpu_ce !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("rst_ex_reached", t < 100, 1'b1);
      reset = 1'b1;
      #1;
      check_eq("rst_ex_ce", cpu_ce, 1'b0);
      check_eq("rst_ex_count", cycle_count, 16'h0);
      run_sw = 1'b0;
      settle(2);
      reset = 1'b0;
      obs_q.delete(); exp_q.delete();
      settle(30);
      cmp_pulses("rst_ex_after");

      t = 0;
      while (!sat_done && t < 300000) begin
         @(negedge clk);
         t++;
      end
      check_eq("sat_finished", sat_done, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
